serial_subtractor: RTL and testbench

- Bit-serial N-bit full subtractor: the inverse operation to the team's full_adder cell.
- Accepts minuend, subtrahend and borrow-in on a start pulse, then processes one bit per clock, LSB first, through a single full-subtractor slice with a registered borrow.
- Presents the difference and borrow-out with a one-cycle done strobe.
- Used as an area-lean arithmetic unit and as the self-check counterpart for adder datapaths.

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit full subtractor.
// Operands are captured on an accepted start pulse. One full-subtractor slice
// then processes one bit per clock, LSB first, and a flop holds the borrow
// between bits. The difference and borrow-out are presented with a
// single-cycle done strobe. They hold their value until the next operation
// completes or a reset occurs.
// Optional feature macro: SERIAL_SUB_ADD_EN. When it is defined, an 'op'
// input selects addition (1) or subtraction (0). In add mode the same slice
// produces a carry chain: b_in acts as carry-in and b_out reports carry-out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
`ifdef SERIAL_SUB_ADD_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  // The counter only needs to reach WIDTH-1, so the last bit is detected
  // without an extra counter bit.
  localparam int CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  // The result register keeps only WIDTH-1 bits. The final bit goes straight
  // from the slice into diff, so the register never needs the last position.
  logic [WIDTH-2:0] result_q, result_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bOut_q, bOut_d;
`ifdef SERIAL_SUB_ADD_EN
  logic             op_q, op_d;
`endif

  logic             sliceX;
  logic             sliceY;
  logic             sliceBit;
  logic             sliceNext;
  logic [WIDTH-1:0] resultFull;

  // Single arithmetic slice: current LSBs plus the stored borrow/carry.
  always_comb begin
    sliceX    = aShift_q[0];
    sliceY    = bShift_q[0];
    sliceBit  = sliceX ^ sliceY ^ borrow_q;
    sliceNext = (~sliceX & sliceY) | (~(sliceX ^ sliceY) & borrow_q);
`ifdef SERIAL_SUB_ADD_EN
    if (op_q) begin
      sliceNext = (sliceX & sliceY) | (borrow_q & (sliceX ^ sliceY));
    end
`endif
    resultFull = {sliceBit, result_q};
  end

  // Next-state logic: capture operands in IDLE, shift one bit per cycle in SHIFT.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    result_d = result_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bOut_d   = bOut_q;
`ifdef SERIAL_SUB_ADD_EN
    op_d     = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          aShift_d = a;
          bShift_d = b;
          borrow_d = b_in;
          result_d = '0;
          count_d  = '0;
`ifdef SERIAL_SUB_ADD_EN
          op_d     = op;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        result_d = (WIDTH-1)'(resultFull >> 1);
        borrow_d = sliceNext;
        count_d  = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          diff_d  = resultFull;
          bOut_d  = sliceNext;
          count_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      result_q <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bOut_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      op_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      result_q <= result_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bOut_q   <= bOut_d;
`ifdef SERIAL_SUB_ADD_EN
      op_q     <= op_d;
`endif
    end
  end

  // Status and result outputs are decoded directly from registers.
  always_comb begin
    busy  = (state_q == SHIFT);
    done  = (state_q == DONE);
    diff  = diff_q;
    b_out = bOut_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8).
// Expected results come from integer arithmetic on the operands.
// The directed add-mode cases are only built when SERIAL_SUB_ADD_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bIn = 1'b0;
`ifdef SERIAL_SUB_ADD_EN
  logic         op = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bOut;

  typedef struct {
    logic [W-1:0] diff;
    logic         bOut;
    int           doneCycle;
  } exp_t;

  exp_t         sb[$];
  int           assertCount = 0;
  int           failCount = 0;
  int           cycleCount = 0;
  int           busyRun = 0;
  int           doneCount = 0;
  logic         prevDone = 1'b0;
  logic [W-1:0] lastDiff = '0;
  logic         lastBOut = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (bIn),
`ifdef SERIAL_SUB_ADD_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (bOut)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges so that done latency can be measured.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [W:0] refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic addMode);
    longint r;
    longint modulus;
    logic   flag;
    modulus = longint'(1) << W;
    if (addMode) begin
      r    = longint'(x) + longint'(y) + longint'(c);
      flag = (r >= modulus);
    end else begin
      r    = longint'(x) - longint'(y) - longint'(c);
      flag = (r < 0);
    end
    if (r < 0) r = r + modulus;
    r = r % modulus;
    return {flag, r[W-1:0]};
  endfunction

  // Monitor: each done is matched against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyRun  = 0;
      prevDone = 1'b0;
    end else begin
      if (busy) busyRun++;
      if (done) begin
        doneCount++;
        checkOutput("doneSingleCycle", {31'd0, prevDone}, 32'd0);
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected no pending op (diff=0x%0h)", diff);
        end else begin
          e = sb.pop_front();
          checkOutput("diff", {24'd0, diff}, {24'd0, e.diff});
          checkOutput("bOut", {31'd0, bOut}, {31'd0, e.bOut});
          checkOutput("latency", cycleCount, e.doneCycle);
          checkOutput("busyLength", busyRun, W);
          lastDiff = e.diff;
          lastBOut = e.bOut;
        end
        busyRun = 0;
      end else if (sb.size() > 0 && cycleCount > sb[0].doneCycle) begin
        e = sb.pop_front();
        assertCount++;
        failCount++;
        $display("[TB] FAIL doneTimeout: got no done by cycle %0d, expected at cycle %0d", cycleCount, e.doneCycle);
        busyRun = 0;
      end
      prevDone = done;
    end
  end

  // Issue one operation at the first idle negedge and push its expected result.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c, input logic o);
    logic [W:0] r;
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy || done) && guard < 100);
    if (guard >= 100) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL idleTimeout: got busy=%0b done=%0b, expected idle", busy, done);
    end
    start = 1'b1;
    a     = x;
    b     = y;
    bIn   = c;
`ifdef SERIAL_SUB_ADD_EN
    op    = o;
`endif
    r = refModel(x, y, c, o);
    sb.push_back('{diff: r[W-1:0], bOut: r[W], doneCycle: cycleCount + 1 + W});
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bIn   = 1'($urandom);
  endtask

  // Wait, with a bound, until every issued operation has completed and the DUT is idle.
  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL waitIdle: got %0d pending ops, expected 0", sb.size());
    end
  endtask

  // Main stimulus sequence.
  initial begin
    int doneBefore;
    logic [W-1:0] rx, ry;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetDiff", {24'd0, diff}, 32'd0);
    checkOutput("resetBOut", {31'd0, bOut}, 32'd0);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h03, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h05, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0);
    waitIdle();
    repeat (10) begin
      @(negedge clk);
      checkOutput("holdDiff", {24'd0, diff}, {24'd0, lastDiff});
      checkOutput("holdBOut", {31'd0, bOut}, {31'd0, lastBOut});
    end

    $display("[TB] start ignored while busy");
    doneBefore = doneCount;
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (W + 4) @(negedge clk);
    checkOutput("singleDone", doneCount - doneBefore, 32'd1);

    $display("[TB] reset during SHIFT");
    doneBefore = doneCount;
    applyStimulus(8'hF0, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("midResetDone", {31'd0, done}, 32'd0);
    checkOutput("midResetDiff", {24'd0, diff}, 32'd0);
    checkOutput("midResetBOut", {31'd0, bOut}, 32'd0);
    lastDiff = '0;
    lastBOut = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * W) @(negedge clk);
    checkOutput("noDoneAfterReset", doneCount - doneBefore, 32'd0);
    applyStimulus(8'h09, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
    $display("[TB] add/subtract mode select");
    applyStimulus(8'hFF, 8'h01, 1'b1, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
`endif

    $display("[TB] randomized back-to-back operations");
    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      if (i == 0) begin rx = 8'h00; ry = 8'hFF; end
      if (i == 1) begin rx = 8'hFF; ry = 8'h00; end
      if (i == 2) begin rx = 8'hFF; ry = 8'hFF; end
`ifdef SERIAL_SUB_ADD_EN
      applyStimulus(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      applyStimulus(rx, ry, 1'($urandom_range(0, 1)), 1'b0);
`endif
    end
    waitIdle();
    checkOutput("pendingOps", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
